// File: rtl/mipi_csi_packet_encoder.sv
// CSI-2 long-packet builder for a 4-lane link, running on the MIPI byte clock.
// It emits the sync word, the header with ECC, the payload, the CRC-16 footer and
// then a forced idle gap. Lane 0 is carried in data_o[7:0] and lane 3 in data_o[31:24].
// Build option: define MIPI_CSI_ENCODER_CRC_EN to put the payload CRC-16 in the footer.
// Without it the footer CRC bytes are zero. Timing is the same in both builds.
module mipi_csi_packet_encoder #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic [7:0]           data_type_i,
  input  logic [15:0]          word_count_i,
  output logic                 ready_o,
  input  logic                 payload_valid_i,
  input  logic [8*LANES-1:0]   payload_i,
  output logic                 payload_ready_o,
  output logic                 output_valid_o,
  output logic [8*LANES-1:0]   data_o,
  output logic                 busy_o,
  output logic                 error_o
);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StHeader,
    StPayload,
    StFooter,
    StGap
  } state_e;

  localparam logic [8*LANES-1:0] SyncWord = {LANES{8'hB8}};

  state_e             state_q, state_d;
  logic [7:0]         di_q, di_d;
  logic [15:0]        wc_q, wc_d;
  logic [13:0]        pay_cnt_q, pay_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [8*LANES-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [8*LANES-1:0] pay_word;
  logic [15:0]        footer_crc;

  // CSI-2 header ECC: six Hamming parity bits over {WC, DI}, where d[0] is DI bit 0.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^
           d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^
           d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

`ifdef MIPI_CSI_ENCODER_CRC_EN
  logic [15:0] crc_q, crc_d;

  // Reflected CRC-16 (0x8408). Bit 0 of lane 0 goes in first, lane 3 goes in last.
  function automatic logic [15:0] crc_fold(input logic [15:0] crc,
                                           input logic [8*LANES-1:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8 * LANES; i++) begin
      c = (c[0] ^ word[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  assign footer_crc = crc_q;
`else
  assign footer_crc = 16'h0000;
`endif

  // When the source underruns, the slot is zero-filled so that the packet length stays fixed.
  assign pay_word = payload_valid_i ? payload_i : '0;

  // Next-state logic for the sequencer, the counters and the registered output word.
  always_comb begin
    state_d   = state_q;
    di_d      = di_q;
    wc_d      = wc_q;
    pay_cnt_d = pay_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = '0;
    valid_d   = 1'b0;
    error_d   = 1'b0;
`ifdef MIPI_CSI_ENCODER_CRC_EN
    crc_d     = crc_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (word_count_i[1:0] == 2'b00) begin
            di_d      = data_type_i;
            wc_d      = word_count_i;
            pay_cnt_d = word_count_i[15:2];
`ifdef MIPI_CSI_ENCODER_CRC_EN
            crc_d     = 16'hFFFF;
`endif
            state_d   = StSync;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StSync: begin
        data_d  = SyncWord;
        valid_d = 1'b1;
        state_d = StHeader;
      end
      StHeader: begin
        data_d  = {2'b00, ecc6({wc_q, di_q}), wc_q, di_q};
        valid_d = 1'b1;
        state_d = (pay_cnt_q == 14'd0) ? StFooter : StPayload;
      end
      StPayload: begin
        data_d    = pay_word;
        valid_d   = 1'b1;
        error_d   = ~payload_valid_i;
        pay_cnt_d = pay_cnt_q - 14'd1;
`ifdef MIPI_CSI_ENCODER_CRC_EN
        crc_d     = crc_fold(crc_q, pay_word);
`endif
        if (pay_cnt_q == 14'd1) begin
          state_d = StFooter;
        end
      end
      StFooter: begin
        data_d    = {16'h0000, footer_crc};
        valid_d   = 1'b1;
        gap_cnt_d = 8'(GAP_CYCLES - 1);
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers. The synchronous reset also aborts a packet in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      di_q      <= '0;
      wc_q      <= '0;
      pay_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
`ifdef MIPI_CSI_ENCODER_CRC_EN
      crc_q     <= 16'hFFFF;
`endif
    end else begin
      state_q   <= state_d;
      di_q      <= di_d;
      wc_q      <= wc_d;
      pay_cnt_q <= pay_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
`ifdef MIPI_CSI_ENCODER_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign ready_o         = (state_q == StIdle);
  assign payload_ready_o = (state_q == StPayload);
  assign busy_o          = (state_q != StIdle);
  assign output_valid_o  = valid_q;
  assign data_o          = data_q;
  assign error_o         = error_q;

endmodule
